// File: rtl/block_chain_ctrl_if.sv
// SPI command bus between the command FSM (master) and one pixel-block controller (slave).
interface block_chain_ctrl_if #(
  parameter int SPI_ADDR_LEN = 10,
  parameter int SPI_DATA_LEN = 16,
  parameter int SPI_CODE_LEN = 6
);
  logic [SPI_CODE_LEN-1:0] code;
  logic [SPI_ADDR_LEN-1:0] addr;
  logic [SPI_DATA_LEN-1:0] data_in;
  logic [SPI_DATA_LEN-1:0] rd_data;
  logic                    rd_valid;

  modport master (output code, addr, data_in, input rd_data, rd_valid);
  modport slave  (input code, addr, data_in, output rd_data, rd_valid);
endinterface

// File: rtl/block_chain_ctrl.sv
// Pixel-block controller: SPI-mapped record/HP/sample-rate registers, ADC capture buffer
// and slot-timed injection of the captured samples into the inter-block daisy chain.
module block_chain_ctrl #(
  parameter int N_CH         = 4,
  parameter int CH_SEL_W     = 2,
  parameter int BITS_ADC     = 12,
  parameter int REC_LEN      = 12,
  parameter int SLOT_LEN     = 8,
  parameter int SPI_ADDR_LEN = 10,
  parameter int SPI_DATA_LEN = 16,
  parameter int SPI_CODE_LEN = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  block_chain_ctrl_if.slave                spi,
  input  logic [SPI_ADDR_LEN-CH_SEL_W-1:0] reg_map_addr_i,
  input  logic                             adc_ready_i,
  input  logic [N_CH*BITS_ADC-1:0]         adc_data_i,
  input  logic [BITS_ADC:0]                chain_in_i,
  output logic [BITS_ADC:0]                chain_out_o,
  output logic [N_CH*REC_LEN-1:0]          rec_o,
  output logic [1:0]                       samp_rate_mux_o,
  output logic [3:0]                       d_hp_o,
  output logic                             overrun_o
);
  localparam int CNT_W  = $clog2(N_CH*SLOT_LEN+2);
  localparam int SLOT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int IDX_W  = $clog2(N_CH+1);
  localparam logic [REC_LEN-1:0] REC_RST  = REC_LEN'(12'h07E);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N_CH*SLOT_LEN+1);
  localparam logic [SLOT_W-1:0]  SLOT_MAX = SLOT_W'(SLOT_LEN-1);

  localparam logic [SPI_CODE_LEN-1:0] C_RD_REC = SPI_CODE_LEN'(1);
  localparam logic [SPI_CODE_LEN-1:0] C_WR_REC = SPI_CODE_LEN'(4);
  localparam logic [SPI_CODE_LEN-1:0] C_WR_HP  = SPI_CODE_LEN'(5);
  localparam logic [SPI_CODE_LEN-1:0] C_CLR    = SPI_CODE_LEN'(7);
  localparam logic [SPI_CODE_LEN-1:0] C_SET    = SPI_CODE_LEN'(8);
  localparam logic [SPI_CODE_LEN-1:0] C_WR_SR  = SPI_CODE_LEN'(14);
  localparam logic [SPI_CODE_LEN-1:0] C_RD_SR  = SPI_CODE_LEN'(15);
  localparam logic [SPI_CODE_LEN-1:0] C_RD_BUF = SPI_CODE_LEN'(19);
  localparam logic [SPI_CODE_LEN-1:0] C_RD_ST  = SPI_CODE_LEN'(20);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic [REC_LEN-1:0]      rec_q [N_CH];
  logic [BITS_ADC-1:0]     buf_q [N_CH];
  logic [1:0]              samp_q;
  logic [3:0]              d_hp_q;
  logic                    wr_dec_q, rd_dec_q, rd_valid_q;
  logic [SPI_DATA_LEN-1:0] rd_data_q, rd_val;
  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [SLOT_W-1:0]       slot_q;
  logic [IDX_W-1:0]        idx_q;
  logic [1:0]              sync_q;
  logic                    adc_prev_q, overrun_q;
  logic [BITS_ADC:0]       chain_q;

  logic                    hit, ch_ok, is_wr, wr_dec_d, rd_dec_d, rd_first, ovr_clr, pos, busy;
  logic [CH_SEL_W-1:0]     ch;
  logic [REC_LEN-1:0]      sel_rec;
  logic [BITS_ADC-1:0]     sel_buf, inj_word;
  logic                    unused_data;

  assign hit   = (spi.addr[SPI_ADDR_LEN-1:CH_SEL_W] == reg_map_addr_i);
  assign ch    = spi.addr[CH_SEL_W-1:0];
  assign ch_ok = (32'(ch) < N_CH);
  assign is_wr = (spi.code == C_WR_REC) || (spi.code == C_WR_HP) || (spi.code == C_CLR) ||
                 (spi.code == C_SET) || (spi.code == C_WR_SR);
  assign wr_dec_d = ((spi.code == C_WR_REC) && hit && ch_ok) || ((spi.code == C_WR_HP) && hit) ||
                    (spi.code == C_CLR) || (spi.code == C_SET) || (spi.code == C_WR_SR);
  assign rd_dec_d = hit && !is_wr;
  // First cycle of a held read: rd_data is snapshotted here and held until the command drops
  assign rd_first = rd_dec_d && rd_dec_q && !rd_valid_q;
  assign ovr_clr  = rd_first && (spi.code == C_RD_ST) && ch_ok;
  assign pos      = sync_q[1] && !adc_prev_q;
  assign busy     = (state_q == SHIFT);
  assign unused_data = ^spi.data_in;

  always_comb begin
    sel_rec  = '0;
    sel_buf  = '0;
    inj_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (32'(ch) == k) begin
        sel_rec = rec_q[k];
        sel_buf = buf_q[k];
      end
      if (32'(idx_q) == k) inj_word = buf_q[k];
    end
  end

  always_comb begin
    rd_val = '0;
    if (ch_ok) begin
      case (spi.code)
        C_RD_REC: rd_val = SPI_DATA_LEN'({sel_rec, d_hp_q});
        C_RD_SR:  rd_val = SPI_DATA_LEN'(samp_q);
        C_RD_BUF: rd_val = SPI_DATA_LEN'(sel_buf);
        C_RD_ST:  rd_val = SPI_DATA_LEN'({overrun_q, busy, cnt_q});
        default:  rd_val = '0;
      endcase
    end
  end

  // Command side: writes fire once on the rising edge of their decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) rec_q[k] <= REC_RST;
      samp_q     <= 2'b11;
      d_hp_q     <= 4'hF;
      wr_dec_q   <= 1'b0;
      rd_dec_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_dec_q <= wr_dec_d;
      rd_dec_q <= rd_dec_d;
      if (wr_dec_d && !wr_dec_q) begin
        case (spi.code)
          C_WR_REC: for (int k = 0; k < N_CH; k++)
                      if (32'(ch) == k) rec_q[k] <= spi.data_in[REC_LEN-1:0];
          C_WR_HP:  d_hp_q <= spi.data_in[3:0];
          C_CLR:    for (int k = 0; k < N_CH; k++) rec_q[k][REC_LEN-1] <= 1'b0;
          C_SET:    for (int k = 0; k < N_CH; k++) rec_q[k][REC_LEN-1] <= 1'b1;
          C_WR_SR:  samp_q <= spi.data_in[1:0];
          default:  ;
        endcase
      end
      if (rd_dec_d && rd_dec_q) begin
        rd_valid_q <= 1'b1;
        if (!rd_valid_q) rd_data_q <= rd_val;
      end else begin
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end
    end
  end

  // Chain side: a new sample set always wins and restarts the shift from channel 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b00;
      adc_prev_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      slot_q     <= '0;
      idx_q      <= '0;
      overrun_q  <= 1'b0;
      chain_q    <= '1;
      for (int k = 0; k < N_CH; k++) buf_q[k] <= '1;
    end else begin
      sync_q     <= {sync_q[0], adc_ready_i};
      adc_prev_q <= sync_q[1];
      if (ovr_clr) overrun_q <= 1'b0;
      if (pos) begin
        if (state_q == SHIFT) overrun_q <= 1'b1;
        for (int k = 0; k < N_CH; k++) buf_q[k] <= adc_data_i[k*BITS_ADC +: BITS_ADC];
        cnt_q   <= '0;
        slot_q  <= '0;
        idx_q   <= '0;
        state_q <= SHIFT;
      end else if (state_q == SHIFT) begin
        if ((slot_q == '0) && (32'(idx_q) < N_CH)) chain_q <= {1'b0, inj_word};
        else                                       chain_q <= chain_in_i;
        cnt_q <= cnt_q + 1'b1;
        if (slot_q == SLOT_MAX) begin
          slot_q <= '0;
          if (32'(idx_q) < N_CH) idx_q <= idx_q + 1'b1;
        end else begin
          slot_q <= slot_q + 1'b1;
        end
        if (cnt_q == CNT_LAST) state_q <= IDLE;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_rec
    assign rec_o[k*REC_LEN +: REC_LEN] = rec_q[k];
  end

  assign spi.rd_data     = rd_data_q;
  assign spi.rd_valid    = rd_valid_q;
  assign chain_out_o     = chain_q;
  assign samp_rate_mux_o = samp_q;
  assign d_hp_o          = d_hp_q;
  assign overrun_o       = overrun_q;
endmodule

// File: tb/tb_block_chain_ctrl.sv
// Randomised bench for block_chain_ctrl against a cycle-count reference model of the block.
module tb_block_chain_ctrl;
  localparam int NCH  = 4;
  localparam int SLOT = 8;
  localparam int LAST = NCH*SLOT + 1;
  localparam logic [7:0] MAP = 8'h5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_ready = 1'b0;
  logic [47:0] adc_data = '0;
  logic [12:0] chain_in = '0;
  logic [12:0] chain_out;
  logic [47:0] rec;
  logic [1:0]  samp;
  logic [3:0]  dhp;
  logic        overrun;
  logic [7:0]  reg_map = MAP;

  block_chain_ctrl_if bus ();

  block_chain_ctrl dut (
    .clk(clk), .rst_n(rst_n), .spi(bus), .reg_map_addr_i(reg_map),
    .adc_ready_i(adc_ready), .adc_data_i(adc_data), .chain_in_i(chain_in),
    .chain_out_o(chain_out), .rec_o(rec), .samp_rate_mux_o(samp), .d_hp_o(dhp),
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [11:0] rec_m [NCH];
  logic [11:0] buf_m [NCH];
  logic [1:0]  samp_m;
  logic [3:0]  dhp_m;
  logic [12:0] chain_m;
  bit          ovr_m, busy_m, adc_seen_m, clr_pend, auto_adc, rand_chain;
  int          n_edge = 0, p_edge = -1, adc_hi = 0;
  int          cap_q[$];
  int          n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cnt_m();
    if (p_edge < 0) return 0;
    return (n_edge - p_edge > LAST + 1) ? LAST + 1 : n_edge - p_edge;
  endfunction

  function automatic logic [15:0] rd_model(input logic [5:0] c, input int chn);
    case (c)
      6'd1:    return {rec_m[chn], dhp_m};
      6'd15:   return {14'b0, samp_m};
      6'd19:   return {4'b0, buf_m[chn]};
      6'd20:   return {8'b0, ovr_m, busy_m, 6'(cnt_m())};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit is_wr(input logic [5:0] c);
    return (c == 6'd4) || (c == 6'd5) || (c == 6'd7) || (c == 6'd8) || (c == 6'd14);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      rec_m[k] = 12'h07E;
      buf_m[k] = 12'hFFF;
    end
    samp_m = 2'b11; dhp_m = 4'hF; chain_m = 13'h1FFF;
    ovr_m = 0; busy_m = 0; adc_seen_m = 0; clr_pend = 0; p_edge = -1;
    cap_q.delete();
  endtask

  // One clock edge of the model, using the inputs present at that edge
  task automatic model_edge();
    int o;
    if (clr_pend) ovr_m = 0;
    clr_pend = 0;
    if (cap_q.size() > 0 && cap_q[0] == n_edge) begin
      void'(cap_q.pop_front());
      if (busy_m) ovr_m = 1;
      for (int k = 0; k < NCH; k++) buf_m[k] = adc_data[k*12 +: 12];
      p_edge = n_edge;
      busy_m = 1;
    end else if (busy_m) begin
      o = n_edge - p_edge - 1;
      if ((o % SLOT == 0) && (o / SLOT < NCH)) chain_m = {1'b0, buf_m[o/SLOT]};
      else                                     chain_m = chain_in;
      if (o == LAST) busy_m = 0;
    end
    // an adc_ready rise first seen on this edge is acted on two edges later
    if (adc_ready && !adc_seen_m) cap_q.push_back(n_edge + 2);
    adc_seen_m = adc_ready;
  endtask

  task automatic drive_adc_auto();
    if (adc_ready) begin
      if (adc_hi == 0) adc_ready = 1'b0;
      else adc_hi--;
    end else if ($urandom_range(0, 39) == 0) begin
      adc_data  = 48'({$urandom(), $urandom()});
      adc_ready = 1'b1;
      adc_hi    = $urandom_range(0, 3);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n_edge++;
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    check_eq("chain_out", 32'(chain_out), 32'(chain_m));
    check_eq("overrun", 32'(overrun), 32'(ovr_m));
    if (auto_adc) drive_adc_auto();
    if (rand_chain) chain_in = 13'($urandom());
  endtask

  task automatic bus_idle();
    bus.code = 6'd0; bus.addr = {8'hFF, 2'b00}; bus.data_in = 16'h0;
  endtask

  task automatic check_cfg();
    for (int k = 0; k < NCH; k++) check_eq($sformatf("rec%0d", k), 32'(rec[k*12 +: 12]), 32'(rec_m[k]));
    check_eq("samp_rate_mux", 32'(samp), 32'(samp_m));
    check_eq("d_hp", 32'(dhp), 32'(dhp_m));
  endtask

  task automatic do_cmd(input logic [5:0] c, input logic [9:0] a, input logic [15:0] d,
                        input int hold, output logic [15:0] got);
    bit          h, wr, v;
    int          chn;
    logic [15:0] exp;
    h = (a[9:2] == MAP); chn = int'(a[1:0]); wr = is_wr(c); v = !wr && h;
    bus.code = c; bus.addr = a; bus.data_in = d;
    tick();
    if (wr) begin
      case (c)
        6'd4:  if (h) rec_m[chn] = d[11:0];
        6'd5:  if (h) dhp_m = d[3:0];
        6'd7:  for (int k = 0; k < NCH; k++) rec_m[k][11] = 1'b0;
        6'd8:  for (int k = 0; k < NCH; k++) rec_m[k][11] = 1'b1;
        default: samp_m = d[1:0];
      endcase
    end
    check_eq("rd_valid_decode", 32'(bus.rd_valid), 0);
    exp = v ? rd_model(c, chn) : 16'h0;
    if (v && c == 6'd20) clr_pend = 1;
    tick();
    got = bus.rd_data;
    for (int i = 2; i <= hold; i++) begin
      if (i > 2) tick();
      check_eq("rd_valid", 32'(bus.rd_valid), 32'(v));
      check_eq($sformatf("rd_data_c%0d", c), 32'(bus.rd_data), 32'(exp));
    end
    bus_idle();
    tick();
    check_eq("rd_valid_drop", 32'(bus.rd_valid), 0);
    check_eq("rd_data_drop", 32'(bus.rd_data), 0);
    check_cfg();
  endtask

  task automatic adc_pulse(input logic [47:0] d);
    adc_data = d; adc_ready = 1'b1;
    tick(); tick();
    adc_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] got;
    logic [5:0]  codes [12];
    logic [5:0]  c;
    logic [7:0]  blk;
    codes = '{6'd1, 6'd4, 6'd5, 6'd7, 6'd8, 6'd14, 6'd15, 6'd19, 6'd20, 6'd2, 6'd33, 6'd0};
    auto_adc = 0; rand_chain = 0;
    bus_idle();
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    check_eq("rst_rd_valid", 32'(bus.rd_valid), 0);
    check_eq("rst_rd_data", 32'(bus.rd_data), 0);
    check_eq("rst_chain", 32'(chain_out), 32'h1FFF);
    check_eq("rst_samp", 32'(samp), 32'h3);
    check_eq("rst_dhp", 32'(dhp), 32'hF);
    for (int k = 0; k < NCH; k++) check_eq("rst_rec", 32'(rec[k*12 +: 12]), 32'h07E);

    do_cmd(6'd1, {MAP, 2'd2}, 16'h0, 3, got);
    check_eq("t1_read_rec2", 32'(got), 32'h07EF);

    do_cmd(6'd4, {MAP, 2'd1}, 16'h0ABC, 5, got);
    check_eq("t2_rec1", 32'(rec[12 +: 12]), 32'hABC);
    do_cmd(6'd7, {8'hFF, 2'd0}, 16'h0, 3, got);
    check_eq("t2_rec1_clr", 32'(rec[12 +: 12]), 32'h2BC);
    check_eq("t2_rec0_clr", 32'(rec[0 +: 12]), 32'h07E);
    check_eq("t2_rec3_clr", 32'(rec[36 +: 12]), 32'h07E);
    do_cmd(6'd8, {8'hFF, 2'd0}, 16'h0, 3, got);
    check_eq("t2_rec2_set", 32'(rec[24 +: 12]), 32'h87E);
    do_cmd(6'd5, {MAP, 2'd3}, 16'h0005, 3, got);
    do_cmd(6'd14, {8'h00, 2'd0}, 16'h0002, 4, got);
    do_cmd(6'd15, {MAP, 2'd0}, 16'h0, 3, got);
    check_eq("t2_read_sr", 32'(got), 32'h0002);

    chain_in = 13'h0055;
    adc_pulse({12'h444, 12'h333, 12'h222, 12'h111});
    repeat (45) tick();
    do_cmd(6'd19, {MAP, 2'd3}, 16'h0, 3, got);
    check_eq("t3_read_buf3", 32'(got), 32'h0444);

    adc_pulse({12'h888, 12'h777, 12'h666, 12'h555});
    for (int i = 0; i < 60; i++) begin
      if (busy_m && cnt_m() == 7) break;
      tick();
    end
    adc_pulse({12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA});
    repeat (50) tick();
    check_eq("t4_overrun_out", 32'(overrun), 1);
    do_cmd(6'd20, {MAP, 2'd0}, 16'h0, 3, got);
    check_eq("t4_status_ovr", 32'(got[7]), 1);
    do_cmd(6'd20, {MAP, 2'd0}, 16'h0, 3, got);
    check_eq("t4_status_ovr_clr", 32'(got[7]), 0);

    do_cmd(6'd4, {MAP, 2'd0}, 16'h0123, 3, got);
    adc_pulse({12'h999, 12'h999, 12'h999, 12'h999});
    for (int i = 0; i < 60; i++) begin
      if (busy_m && cnt_m() == 12) break;
      tick();
    end
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_chain_rst", 32'(chain_out), 32'h1FFF);
    check_eq("t5_rec0_rst", 32'(rec[0 +: 12]), 32'h07E);
    tick();
    rst_n = 1'b1;
    do_cmd(6'd20, {MAP, 2'd0}, 16'h0, 3, got);
    check_eq("t5_status", 32'(got), 32'h0000);
    do_cmd(6'd19, {MAP, 2'd1}, 16'h0, 3, got);
    check_eq("t5_buf1", 32'(got), 32'h0FFF);

    do_cmd(6'd4, {8'h12, 2'd1}, 16'h0555, 3, got);
    do_cmd(6'd5, {8'h12, 2'd1}, 16'h0003, 3, got);
    do_cmd(6'd1, {8'h12, 2'd1}, 16'h0000, 4, got);
    check_eq("t6_rec1", 32'(rec[12 +: 12]), 32'h07E);
    check_eq("t6_dhp", 32'(dhp), 32'hF);

    auto_adc = 1; rand_chain = 1;
    for (int i = 0; i < 250; i++) begin
      c   = codes[$urandom_range(0, 11)];
      blk = ($urandom_range(0, 4) != 0) ? MAP : 8'($urandom_range(0, 255));
      if (blk == MAP && $urandom_range(0, 4) == 0) blk = MAP ^ 8'h01;
      do_cmd(c, {blk, 2'($urandom_range(0, 3))}, 16'($urandom()), $urandom_range(3, 6), got);
      repeat ($urandom_range(0, 2)) tick();
    end
    auto_adc = 0;
    adc_ready = 1'b0;
    repeat (50) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
